dpi_comm_tx_arb: RTL and testbench

- Round-robin, packet-locking arbiter that shares one 64-bit host-bound dpi_comm transmit stream among N on-chip requesters.
- Sits between requester logic and the tx_data/tx_valid/tx_ready side of a dpi_comm instance.
- Registers one output beat and tags it with the source index so host software can demultiplex.
- Bounds packet length so a requester that never asserts last cannot starve the others.

---
 rtl/dpi_comm_tx_arb_if.sv | 31 +++
 rtl/dpi_comm_tx_arb.sv | 115 +++++++++++
 tb/tb_dpi_comm_tx_arb.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dpi_comm_tx_arb_if.sv
// Requester and downstream bundle for dpi_comm_tx_arb.
// master drives requests and out_ready; slave is the arbiter.
interface dpi_comm_tx_arb_if #(
  parameter int N = 4,
  parameter int W = 64
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_last;
  logic [SW-1:0]  out_src;
  logic           out_ready;
  logic           busy;

  modport master (
    output req_data, req_valid, req_last, out_ready,
    input  req_ready, out_data, out_valid, out_last,
    input  out_src, busy
  );

  modport slave (
    input  req_data, req_valid, req_last, out_ready,
    output req_ready, out_data, out_valid, out_last,
    output out_src, busy
  );
endinterface

// File: rtl/dpi_comm_tx_arb.sv
// Round-robin, packet-locking arbiter onto one registered
// dpi_comm tx beat, tagged with its source index.
module dpi_comm_tx_arb #(
  parameter int N         = 4,
  parameter int W         = 64,
  parameter int LOCK_PKT  = 1,
  parameter int MAX_BEATS = 256
) (
  input logic              clk,
  input logic              reset,
  dpi_comm_tx_arb_if.slave bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW:0]   MAXB     = (CW+1)'(MAX_BEATS);
  localparam logic [SW-1:0] LAST_IDX = SW'(N - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state_q;
  logic [SW-1:0] owner_q;
  logic [SW-1:0] rr_ptr_q;
  logic [CW-1:0] beat_cnt_q;
  logic [W-1:0]  out_data_q;
  logic [SW-1:0] out_src_q;
  logic          out_valid_q;
  logic          out_last_q;
  logic          busy_q;

  logic [W-1:0]  data_a [N];
  logic [SW-1:0] idx;
  logic [SW-1:0] winner;
  logic [SW-1:0] sel;
  logic [SW-1:0] rr_ptr_d;
  logic [CW:0]   cnt_d;
  logic [N-1:0]  ready;
  logic          found;
  logic          slot_free;
  logic          accept;
  logic          pkt_end;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign data_a[i] = bus.req_data[i*W +: W];
  end

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = SW'((int'(rr_ptr_q) + k) % N);
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Only the owner may be granted while locked, even when it idles.
  always_comb begin
    slot_free = !out_valid_q || bus.out_ready;
    sel       = (state_q == LOCKED) ? owner_q : winner;
    ready     = '0;
    if (!reset) begin
      if (state_q == LOCKED)
        ready[owner_q] = slot_free && bus.req_valid[owner_q];
      else if (found)
        ready[winner] = slot_free;
    end
    accept   = |ready;
    cnt_d    = {1'b0, beat_cnt_q} + (CW+1)'(1);
    pkt_end  = (LOCK_PKT == 0) || bus.req_last[sel] ||
               (cnt_d == MAXB);
    rr_ptr_d = (sel == LAST_IDX) ? '0 : sel + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else if (accept) begin
      out_data_q  <= data_a[sel];
      out_last_q  <= bus.req_last[sel];
      out_src_q   <= sel;
      out_valid_q <= 1'b1;
      if (pkt_end) begin
        state_q    <= IDLE;
        busy_q     <= 1'b0;
        rr_ptr_q   <= rr_ptr_d;
        beat_cnt_q <= '0;
      end else begin
        state_q    <= LOCKED;
        busy_q     <= 1'b1;
        owner_q    <= sel;
        beat_cnt_q <= cnt_d[CW-1:0];
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready = ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_src   = out_src_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_dpi_comm_tx_arb.sv
// Scoreboard bench for dpi_comm_tx_arb (N=4, MAX_BEATS=4).
// One thread: cyc() samples at negedge and drives after posedge.
module tb_dpi_comm_tx_arb;
  localparam int N = 4;
  localparam int W = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dpi_comm_tx_arb_if #(.N(N), .W(W)) bus ();

  dpi_comm_tx_arb #(
    .N(N), .W(W), .LOCK_PKT(1), .MAX_BEATS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int busy_cycles = 0;
  int src_cnt [N];
  int obs_cyc [$];
  logic [66:0] sb [$];
  logic [W:0] rmem [N][64];
  int rhead [N];
  int rtail [N];
  logic [N-1:0] acc;

  task automatic push_beat(input int i, input logic [W-1:0] d,
                           input logic l);
    rmem[i][rtail[i] % 64] = {l, d};
    rtail[i]++;
  endtask

  task automatic expect_beat(input int s, input logic [W-1:0] d,
                             input logic l);
    sb.push_back({2'(s), l, d});
  endtask

  function automatic bit reqs_empty();
    for (int i = 0; i < N; i++)
      if (rhead[i] != rtail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic present();
    logic [W:0] ent;
    for (int i = 0; i < N; i++) begin
      if (rhead[i] != rtail[i]) begin
        ent = rmem[i][rhead[i] % 64];
        bus.req_valid[i] = 1'b1;
        bus.req_last[i]  = ent[W];
        bus.req_data[i*W +: W] = ent[W-1:0];
      end else begin
        bus.req_valid[i] = 1'b0;
        bus.req_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic cyc();
    logic [66:0] got;
    logic [66:0] exp_b;
    @(negedge clk);
    if (!reset && bus.out_valid && bus.out_ready) begin
      got = {bus.out_src, bus.out_last, bus.out_data};
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_extra got src=%0d last=%0d data=%h expected none",
                 got[66:65], got[64], got[63:0]);
      end else begin
        exp_b = sb.pop_front();
        if (got !== exp_b) begin
          failures++;
          $display("FAIL sb_beat got src=%0d last=%0d data=%h expected src=%0d last=%0d data=%h",
                   got[66:65], got[64], got[63:0],
                   exp_b[66:65], exp_b[64], exp_b[63:0]);
        end
      end
      obs_cyc.push_back(cycle);
      src_cnt[bus.out_src]++;
    end
    if (bus.busy) busy_cycles++;
    acc = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    cycle++;
    for (int i = 0; i < N; i++)
      if (acc[i]) rhead[i]++;
    present();
    #1;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      cyc();
      if (sb.size() == 0 && reqs_empty() && !bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    push_beat(0, 64'hA0, 1'b1);
    push_beat(2, 64'hA2, 1'b1);
    expect_beat(0, 64'hA0, 1'b1);
    expect_beat(2, 64'hA2, 1'b1);
    cyc();
    cyc();
    checks += 6;
    if (bus.out_valid !== 1'b0) begin failures++;
      $display("FAIL rst_valid got %b expected 0", bus.out_valid); end
    if (bus.out_data !== 64'h0) begin failures++;
      $display("FAIL rst_data got %h expected 0", bus.out_data); end
    if (bus.out_last !== 1'b0) begin failures++;
      $display("FAIL rst_last got %b expected 0", bus.out_last); end
    if (bus.out_src !== 2'd0) begin failures++;
      $display("FAIL rst_src got %0d expected 0", bus.out_src); end
    if (bus.busy !== 1'b0) begin failures++;
      $display("FAIL rst_busy got %b expected 0", bus.busy); end
    if (bus.req_ready !== 4'b0000) begin failures++;
      $display("FAIL rst_ready got %b expected 0000", bus.req_ready); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int base;
    bit ok;
    base = obs_cyc.size();
    wait_drain(20, ok);
    checks++;
    if (!ok) begin failures++;
      $display("FAIL basic_drain got timeout expected idle"); end
    checks++;
    if (obs_cyc.size() != base + 2) begin failures++;
      $display("FAIL basic_count got %0d expected 2", obs_cyc.size() - base);
    end else begin
      checks++;
      if (obs_cyc[base+1] - obs_cyc[base] != 1) begin failures++;
        $display("FAIL basic_consec got gap %0d expected 1",
                 obs_cyc[base+1] - obs_cyc[base]); end
    end
  endtask

  task automatic test_rr_ptr();
    bit ok;
    for (int i = 0; i < N; i++) push_beat(i, 64'hB0 + 64'(i), 1'b1);
    expect_beat(3, 64'hB3, 1'b1);
    expect_beat(0, 64'hB0, 1'b1);
    expect_beat(1, 64'hB1, 1'b1);
    expect_beat(2, 64'hB2, 1'b1);
    wait_drain(20, ok);
    checks++;
    if (!ok) begin failures++;
      $display("FAIL rr_drain got timeout expected idle"); end
  endtask

  task automatic test_lock();
    int base;
    int b0;
    bit ok;
    base = obs_cyc.size();
    b0 = busy_cycles;
    push_beat(1, 64'hC10, 1'b0);
    push_beat(1, 64'hC11, 1'b0);
    push_beat(1, 64'hC12, 1'b1);
    expect_beat(1, 64'hC10, 1'b0);
    expect_beat(1, 64'hC11, 1'b0);
    expect_beat(1, 64'hC12, 1'b1);
    cyc();
    push_beat(0, 64'hC00, 1'b1);
    expect_beat(0, 64'hC00, 1'b1);
    wait_drain(30, ok);
    checks += 2;
    if (!ok) begin failures++;
      $display("FAIL lock_drain got timeout expected idle"); end
    if (busy_cycles - b0 != 2) begin failures++;
      $display("FAIL lock_busy got %0d cycles expected 2",
               busy_cycles - b0); end
    checks++;
    if (obs_cyc.size() != base + 4) begin failures++;
      $display("FAIL lock_count got %0d expected 4", obs_cyc.size() - base);
    end else begin
      checks++;
      if (obs_cyc[base+2] - obs_cyc[base] != 2) begin failures++;
        $display("FAIL lock_contig got span %0d expected 2",
                 obs_cyc[base+2] - obs_cyc[base]); end
    end
  endtask

  task automatic test_backpressure();
    int base;
    bit ok;
    base = obs_cyc.size();
    bus.out_ready = 1'b0;
    push_beat(1, 64'hD10, 1'b1);
    push_beat(2, 64'hD20, 1'b1);
    expect_beat(1, 64'hD10, 1'b1);
    expect_beat(2, 64'hD20, 1'b1);
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (bus.out_valid) break;
    end
    for (int k = 0; k < 5; k++) begin
      checks += 3;
      if (bus.out_valid !== 1'b1) begin failures++;
        $display("FAIL bp_valid got %b expected 1", bus.out_valid); end
      if (bus.out_data !== 64'hD10) begin failures++;
        $display("FAIL bp_data got %h expected d10", bus.out_data); end
      if (bus.req_ready !== 4'b0000) begin failures++;
        $display("FAIL bp_ready got %b expected 0000", bus.req_ready); end
      cyc();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.out_data !== 64'hD10 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_release got v=%b d=%h expected v=1 d=d10",
               bus.out_valid, bus.out_data);
    end
    wait_drain(20, ok);
    checks += 2;
    if (!ok) begin failures++;
      $display("FAIL bp_drain got timeout expected idle"); end
    if (obs_cyc.size() - base != 2) begin failures++;
      $display("FAIL bp_count got %0d expected 2", obs_cyc.size() - base);
    end
  endtask

  task automatic test_forced_release();
    int base;
    bit ok;
    base = obs_cyc.size();
    for (int k = 0; k < 8; k++) push_beat(3, 64'hE30 + 64'(k), 1'b0);
    push_beat(0, 64'hE00, 1'b1);
    for (int k = 0; k < 4; k++) expect_beat(3, 64'hE30 + 64'(k), 1'b0);
    expect_beat(0, 64'hE00, 1'b1);
    for (int k = 4; k < 8; k++) expect_beat(3, 64'hE30 + 64'(k), 1'b0);
    wait_drain(40, ok);
    checks += 3;
    if (!ok) begin failures++;
      $display("FAIL forced_drain got timeout expected idle"); end
    if (obs_cyc.size() - base != 9) begin failures++;
      $display("FAIL forced_count got %0d expected 9", obs_cyc.size() - base);
    end
    if (bus.busy !== 1'b0) begin failures++;
      $display("FAIL forced_busy got %b expected 0", bus.busy); end
  endtask

  task automatic test_fairness();
    int s0 [N];
    int d;
    int mx;
    int mn;
    int tot;
    bit ok;
    for (int i = 0; i < N; i++) s0[i] = src_cnt[i];
    for (int r = 0; r < 10; r++)
      for (int i = 0; i < N; i++) begin
        push_beat(i, 64'hF000 + 64'(r*16 + i), 1'b1);
        expect_beat(i, 64'hF000 + 64'(r*16 + i), 1'b1);
      end
    for (int c = 0; c < 400; c++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      cyc();
      if (sb.size() == 0 && reqs_empty()) break;
    end
    bus.out_ready = 1'b1;
    wait_drain(20, ok);
    checks++;
    if (!ok) begin failures++;
      $display("FAIL fair_drain got timeout expected idle"); end
    mx = 0;
    mn = 1000;
    tot = 0;
    for (int i = 0; i < N; i++) begin
      d = src_cnt[i] - s0[i];
      tot += d;
      if (d > mx) mx = d;
      if (d < mn) mn = d;
    end
    checks += 2;
    if (mx - mn > 1) begin failures++;
      $display("FAIL fair_spread got %0d expected <=1", mx - mn); end
    if (tot != 40) begin failures++;
      $display("FAIL fair_total got %0d expected 40", tot); end
  endtask

  task automatic test_async_reset();
    bit ok;
    push_beat(2, 64'hF2, 1'b1);
    expect_beat(2, 64'hF2, 1'b1);
    wait_drain(20, ok);
    checks++;
    if (!ok) begin failures++;
      $display("FAIL ar_pre_drain got timeout expected idle"); end
    for (int k = 0; k < 3; k++) push_beat(3, 64'h960 + 64'(k), 1'b0);
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (bus.busy) break;
    end
    checks += 3;
    if (bus.out_valid !== 1'b1) begin failures++;
      $display("FAIL ar_pre_valid got %b expected 1", bus.out_valid); end
    if (bus.busy !== 1'b1) begin failures++;
      $display("FAIL ar_pre_busy got %b expected 1", bus.busy); end
    if (bus.req_ready !== 4'b1000) begin failures++;
      $display("FAIL ar_pre_ready got %b expected 1000", bus.req_ready); end
    #1;
    reset = 1'b1;
    #1;
    checks += 3;
    if (bus.out_valid !== 1'b0) begin failures++;
      $display("FAIL ar_valid got %b expected 0", bus.out_valid); end
    if (bus.busy !== 1'b0) begin failures++;
      $display("FAIL ar_busy got %b expected 0", bus.busy); end
    if (bus.req_ready !== 4'b0000) begin failures++;
      $display("FAIL ar_ready got %b expected 0000", bus.req_ready); end
    for (int i = 0; i < N; i++) rhead[i] = rtail[i];
    cyc();
    cyc();
    reset = 1'b0;
    push_beat(3, 64'h973, 1'b1);
    push_beat(0, 64'h970, 1'b1);
    expect_beat(0, 64'h970, 1'b1);
    expect_beat(3, 64'h973, 1'b1);
    wait_drain(20, ok);
    checks++;
    if (!ok) begin failures++;
      $display("FAIL ar_post_drain got timeout expected idle"); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rr_ptr();
    test_lock();
    test_backpressure();
    test_forced_release();
    test_fairness();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
